// File: rtl/coax_tx_arbiter.sv
// Two-requester, frame-level arbiter in front of a buffered coax transmitter.
// Words from the granted requester pass through unregistered; the frame is then started and tracked until it drains.
module coax_tx_arbiter #(
  parameter int STALL_LIMIT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] req0_data,
  input  logic [9:0] req1_data,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic       req0_last,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       req0_done,
  output logic       req1_done,
  output logic       abort,
  output logic [1:0] grant,
  output logic       busy,
  output logic [9:0] tx_data,
  output logic       tx_load_strobe,
  output logic       tx_start_strobe,
  input  logic       tx_empty,
  input  logic       tx_full,
  input  logic       tx_ready,
  input  logic       tx_active,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STALL_LIMIT);
  localparam logic [CW:0]   LIMIT_W = (CW + 1)'(STALL_LIMIT);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    LOAD        = 3'd1,
    START       = 3'd2,
    WAIT_ACTIVE = 3'd3,
    WAIT_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;       // 1 = requester 1 was served last
  logic          aborted_q, aborted_d;
  logic [CW-1:0] stall_q, stall_d;

  logic          in_load, tx_ok, sel_valid, sel_last, accept, stall_hit;
  logic [9:0]    sel_data;
  logic [CW:0]   stall_plus;
  logic          abort_p, start_p, done_p;

  // Handshake: a word moves when the granted reqN_valid and reqN_ready are both
  // high in the same cycle; ready never depends on valid, and valid/last from the
  // non-granted requester are ignored until the next arbitration in IDLE.
  assign in_load    = (state_q == LOAD);
  assign tx_ok      = !tx_full && tx_ready;
  assign sel_valid  = grant_q[1] ? req1_valid : req0_valid;
  assign sel_last   = grant_q[1] ? req1_last  : req0_last;
  assign sel_data   = grant_q[1] ? req1_data  : req0_data;
  assign accept     = in_load && (grant_q[0] || grant_q[1]) && sel_valid && tx_ok;
  assign stall_plus = {1'b0, stall_q} + {{CW{1'b0}}, 1'b1};
  assign stall_hit  = !accept && (stall_plus >= LIMIT_W);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aborted_d = aborted_q;
    stall_d   = '0;
    abort_p   = 1'b0;
    start_p   = 1'b0;
    done_p    = 1'b0;
    case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        if (req0_valid || req1_valid) begin
          if (req0_valid && req1_valid) grant_d = last_q ? 2'b01 : 2'b10;
          else                          grant_d = req0_valid ? 2'b01 : 2'b10;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (sel_last) state_d = START;
        end else if (stall_hit) begin
          abort_p   = 1'b1;
          aborted_d = 1'b1;
          last_d    = grant_q[1];
          if (!tx_empty) begin
            state_d = START;
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
          end
        end else begin
          stall_d = (stall_q == LIMIT_C) ? stall_q : stall_q + CW'(1);
        end
      end
      START: begin
        start_p = 1'b1;
        state_d = WAIT_ACTIVE;
      end
      WAIT_ACTIVE: begin
        if (tx_active) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_active && tx_empty) begin
          done_p    = !aborted_q;
          if (!aborted_q) last_d = grant_q[1];
          grant_d   = 2'b00;
          aborted_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      aborted_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aborted_q <= aborted_d;
      stall_q   <= stall_d;
    end
  end

  // Everything is forced quiet while reset is held, including before the first edge.
  assign req0_ready      = reset && in_load && grant_q[0] && tx_ok;
  assign req1_ready      = reset && in_load && grant_q[1] && tx_ok;
  assign tx_load_strobe  = reset && accept;
  assign tx_data         = (reset && in_load) ? sel_data : 10'd0;
  assign tx_start_strobe = reset && start_p;
  assign abort           = reset && abort_p;
  assign req0_done       = reset && done_p && grant_q[0];
  assign req1_done       = reset && done_p && grant_q[1];
  assign grant           = reset ? grant_q : 2'b00;
  assign busy            = reset && (state_q != IDLE);
  assign dbg_state       = reset ? state_q : IDLE;

endmodule
